ram_bus_sync: RTL and testbench
===============================

Name: ram_bus_sync

Overview:
- Front-end sampler for the traced PSRAM bus.
- Synchronises every asynchronous RAM-bus pin into the mclk domain and deglitches ram_clk.
- Decodes chip-select, read, write, byte-enable and address-valid, and emits one filter_strobe per clean rising edge of ram_clk.
- Feeds the tracing state machine, burst counter, patch store and injection logic with filter_* signals. Also captures falling-edge data (nfilter_d) for read tracing.

Parameters:
- FILTER_DEPTH, 3: consecutive identical synchronised ram_clk samples required before the filtered clock changes state. Legal range 1..8.

Ports:
- mclk  input  1  system clock; all logic is on its rising edge
- reset  input  1  asynchronous, active-high reset
- ram_a  input  23  RAM address bus
- ram_d  input  16  RAM data bus, sampled only
- ram_oe  input  1  output enable, active-low
- ram_we  input  1  write enable, active-low
- ram_ce1  input  1  chip enable 1, active-low; the raw pin, not the injection override
- ram_ce2  input  1  chip enable 2, active-high
- ram_ub  input  1  upper byte enable, active-low
- ram_lb  input  1  lower byte enable, active-low
- ram_adv  input  1  address valid, active-low
- ram_clk  input  1  RAM burst clock
- filter_a  output  23  address at the last strobe
- filter_d  output  16  data at the last strobe, rising edge
- filter_ublb  output  2  {upper, lower} byte enables, active-high
- filter_read  output  1  read cycle at the last strobe
- filter_write  output  1  write cycle at the last strobe
- filter_addr_latch  output  1  address-latch cycle at the last strobe
- filter_strobe  output  1  one-mclk pulse; filter_* updated this cycle
- nfilter_d  output  16  data at the last filtered falling edge of ram_clk
- glitch_count  output  16  rejected ram_clk transitions (see Optional Feature)

Behaviour:
- Reset values: every output is 0. All synchroniser stages are 0. clk_filt is 0. The history register is 0.
- Synchronisation: every input passes through two mclk flops (s1, s2). Only s2 values are used downstream.
- Glitch filter:
  - Shift s2 ram_clk into a FILTER_DEPTH-bit history register.
  - clk_filt becomes 1 when all history bits are 1 and clk_filt is 0.
  - clk_filt becomes 0 when all history bits are 0 and clk_filt is 1.
  - Otherwise clk_filt holds.
- Rising edge (clk_filt 0->1, decided on cycle N):
  - On cycle N+1, filter_strobe=1 and all filter_* outputs are loaded from the s2 values present on cycle N.
  - filter_strobe is 1 for exactly one cycle.
  - Between strobes all filter_* outputs hold their values.
- Falling edge (clk_filt 1->0): nfilter_d is loaded on the next cycle from s2 ram_d. It holds otherwise. No strobe is generated.
- Decode, evaluated on s2 values:
  - sel = !ram_ce1 && ram_ce2
  - filter_read = sel && !ram_oe && ram_we
  - filter_write = sel && !ram_we; write takes priority over read if both oe and we are low
  - filter_addr_latch = sel && !ram_adv; may coincide with read or write
  - filter_ublb = {!ram_ub, !ram_lb}, not gated by sel
- Latency: a ram_clk pin rising edge produces filter_strobe 2 (sync) + FILTER_DEPTH + 1 mclk cycles later.
- Timing constraint: each ram_clk half-period must be at least FILTER_DEPTH+3 mclk cycles, with bus signals stable through it. Faster clocks are out of spec; edges may be dropped, but the block must never strobe twice for one rising edge.
- Pulses shorter than FILTER_DEPTH cycles never move clk_filt.
- Reset asserted mid-burst:
  - All state returns to reset values immediately.
  - The first strobe after reset release requires a full low-then-high filtered sequence.
  - If ram_clk is high at release, history fills to all-ones and produces a strobe FILTER_DEPTH+3 cycles later. That strobe is accepted behaviour.

Optional Feature:
- Macro: RAM_BUS_SYNC_GLITCH_CNT_EN.
- Defined:
  - glitch_count increments by 1 each time s2 ram_clk differs from clk_filt and then returns to equal clk_filt before clk_filt changes.
  - The count saturates at 16'hFFFF and resets to 0.
- Undefined: glitch_count is tied to 16'h0000 and no counter logic is built.

Test Plan:
- Reset, then idle (ram_clk=0, ce1=1, ce2=0) for 100 cycles -> all outputs 0, no filter_strobe.
- Address latch: ce1=0, ce2=1, adv=0, ram_a=23'h12345, ram_clk low 8 cycles then high 8 cycles (FILTER_DEPTH=3) -> single strobe 6 cycles after the rising pin edge, with filter_addr_latch=1, filter_a=23'h12345, filter_read=0, filter_write=0.
- Write burst: adv=1, we=0, ub=0, lb=1, ram_d=16'hBEEF, 4 clean clocks -> 4 strobes, each filter_write=1, filter_ublb=2'b10, filter_d=16'hBEEF.
- Read with falling-edge data: oe=0, we=1, ram_d=16'hA5A5 while high and 16'h5A5A at the falling edge -> filter_read=1, filter_d=16'hA5A5; after the fall, nfilter_d=16'h5A5A and no extra strobe.
- Glitch: 2-cycle ram_clk high pulse with FILTER_DEPTH=3 -> no strobe. With RAM_BUS_SYNC_GLITCH_CNT_EN, glitch_count=1.
- Reset asserted 1 cycle after a rising pin edge -> no strobe emitted, outputs 0. A clean clock after release yields a normal strobe.

Source files
------------

// File: rtl/ram_bus_sync_if.sv
// ram_bus_sync_if
// Bundles the traced PSRAM pins and the filtered sampler outputs.
//   slave  : the sampler; receives ram_* pins, drives filter_*, nfilter_d, glitch_count
//   master : the pin source; drives ram_* pins, observes the sampler outputs
// ram_* pins keep the board polarity (active-low strobes except ram_ce2).
interface ram_bus_sync_if;
    logic [22:0] ram_a;
    logic [15:0] ram_d;
    logic        ram_oe;
    logic        ram_we;
    logic        ram_ce1;
    logic        ram_ce2;
    logic        ram_ub;
    logic        ram_lb;
    logic        ram_adv;
    logic        ram_clk;

    logic [22:0] filter_a;
    logic [15:0] filter_d;
    logic [1:0]  filter_ublb;
    logic        filter_read;
    logic        filter_write;
    logic        filter_addr_latch;
    logic        filter_strobe;
    logic [15:0] nfilter_d;
    logic [15:0] glitch_count;

    modport slave (
        input  ram_a, ram_d, ram_oe, ram_we, ram_ce1, ram_ce2,
               ram_ub, ram_lb, ram_adv, ram_clk,
        output filter_a, filter_d, filter_ublb, filter_read, filter_write,
               filter_addr_latch, filter_strobe, nfilter_d, glitch_count
    );

    modport master (
        output ram_a, ram_d, ram_oe, ram_we, ram_ce1, ram_ce2,
               ram_ub, ram_lb, ram_adv, ram_clk,
        input  filter_a, filter_d, filter_ublb, filter_read, filter_write,
               filter_addr_latch, filter_strobe, nfilter_d, glitch_count
    );
endinterface

// File: rtl/ram_bus_sync.sv
// ram_bus_sync
// Front-end sampler for the traced PSRAM bus. Every asynchronous pin is
// brought into the mclk domain through two flops, ram_clk is deglitched by
// a FILTER_DEPTH-sample history, and each clean rising edge of the filtered
// clock produces a one-cycle filter_strobe together with a decoded snapshot
// of the bus. Each clean falling edge captures the data bus into nfilter_d.
//
// Ports:
//   mclk   - system clock, all logic on its rising edge
//   reset  - asynchronous, active-high
//   bus    - ram_bus_sync_if.slave: raw ram_* pins in, filter_* snapshot,
//            filter_strobe, nfilter_d and glitch_count out
//
// Parameter:
//   FILTER_DEPTH (1..8) - identical synchronised ram_clk samples needed
//                         before the filtered clock changes state
//
// Build option:
//   RAM_BUS_SYNC_GLITCH_CNT_EN - when defined, glitch_count counts ram_clk
//   excursions that returned before the filter accepted them (saturating);
//   when undefined glitch_count is a constant zero.
module ram_bus_sync #(
    parameter int FILTER_DEPTH = 3
) (
    input  logic          mclk,
    input  logic          reset,
    ram_bus_sync_if.slave bus
);

    generate
        if (FILTER_DEPTH < 1 || FILTER_DEPTH > 8) begin : g_bad_depth
            $error("ram_bus_sync: FILTER_DEPTH must be in 1..8");
        end
    endgenerate

    typedef struct packed {
        logic [22:0] a;
        logic [15:0] d;
        logic        oe;
        logic        we;
        logic        ce1;
        logic        ce2;
        logic        ub;
        logic        lb;
        logic        adv;
        logic        clk;
    } pins_t;

    typedef enum logic {
        CLK_LOW  = 1'b0,
        CLK_HIGH = 1'b1
    } filt_state_t;

    pins_t pins_raw;
    pins_t pins_s1;
    pins_t pins_s2;

    assign pins_raw = {bus.ram_a, bus.ram_d, bus.ram_oe, bus.ram_we,
                       bus.ram_ce1, bus.ram_ce2, bus.ram_ub, bus.ram_lb,
                       bus.ram_adv, bus.ram_clk};

    // Two-flop synchroniser; only pins_s2 is used downstream.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            pins_s1 <= '0;
            pins_s2 <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its source.
            pins_s1 <= pins_raw;
            pins_s2 <= pins_s1;
        end
    end

    // ------------------------------------------------------------------
    // Glitch filter: two-process state machine on the filtered clock
    // ------------------------------------------------------------------
    logic [FILTER_DEPTH-1:0] hist_q;
    logic [FILTER_DEPTH-1:0] hist_d;
    filt_state_t             state_q;
    filt_state_t             state_d;
    logic                    rise;
    logic                    fall;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        hist_d    = hist_q << 1;
        hist_d[0] = pins_s2.clk;
        state_d   = state_q;
        rise      = 1'b0;
        fall      = 1'b0;
        case (state_q)
            CLK_LOW: begin
                if (&hist_q) begin
                    state_d = CLK_HIGH;
                    rise    = 1'b1;
                end
            end
            CLK_HIGH: begin
                if (~|hist_q) begin
                    state_d = CLK_LOW;
                    fall    = 1'b1;
                end
            end
            default: state_d = CLK_LOW;
        endcase
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            hist_q  <= '0;
            state_q <= CLK_LOW;
        end else begin
            hist_q  <= hist_d;
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Bus decode on synchronised pins
    // ------------------------------------------------------------------
    logic       sel;
    logic       dec_read;
    logic       dec_write;
    logic       dec_addr_latch;
    logic [1:0] dec_ublb;

    always_comb begin
        sel            = !pins_s2.ce1 && pins_s2.ce2;
        // Write wins when oe and we are both low: read requires we high.
        dec_write      = sel && !pins_s2.we;
        dec_read       = sel && !pins_s2.oe && pins_s2.we;
        dec_addr_latch = sel && !pins_s2.adv;
        // Byte enables are reported regardless of chip select.
        dec_ublb       = {!pins_s2.ub, !pins_s2.lb};
    end

    // ------------------------------------------------------------------
    // Snapshot registers
    // ------------------------------------------------------------------
    logic [22:0] filt_a_q;
    logic [15:0] filt_d_q;
    logic [1:0]  filt_ublb_q;
    logic        filt_read_q;
    logic        filt_write_q;
    logic        filt_addr_latch_q;
    logic        filt_strobe_q;
    logic [15:0] nfilt_d_q;

    always_ff @(posedge mclk or posedge reset) begin
        // NOTE: every register here is reset because all outputs must read
        // zero out of reset; there is no storage array to leave unreset.
        if (reset) begin
            filt_a_q          <= '0;
            filt_d_q          <= '0;
            filt_ublb_q       <= '0;
            filt_read_q       <= 1'b0;
            filt_write_q      <= 1'b0;
            filt_addr_latch_q <= 1'b0;
            filt_strobe_q     <= 1'b0;
            nfilt_d_q         <= '0;
        end else begin
            filt_strobe_q <= rise;
            if (rise) begin
                filt_a_q          <= pins_s2.a;
                filt_d_q          <= pins_s2.d;
                filt_ublb_q       <= dec_ublb;
                filt_read_q       <= dec_read;
                filt_write_q      <= dec_write;
                filt_addr_latch_q <= dec_addr_latch;
            end
            if (fall) begin
                nfilt_d_q <= pins_s2.d;
            end
        end
    end

    assign bus.filter_a          = filt_a_q;
    assign bus.filter_d          = filt_d_q;
    assign bus.filter_ublb       = filt_ublb_q;
    assign bus.filter_read       = filt_read_q;
    assign bus.filter_write      = filt_write_q;
    assign bus.filter_addr_latch = filt_addr_latch_q;
    assign bus.filter_strobe     = filt_strobe_q;
    assign bus.nfilter_d         = nfilt_d_q;

    // ------------------------------------------------------------------
    // Rejected-transition counter
    // ------------------------------------------------------------------
`ifdef RAM_BUS_SYNC_GLITCH_CNT_EN
    // deviating_q marks that s2 ram_clk has left the filtered level; if it
    // comes back before the filter flips, that excursion was a glitch.
    logic        deviating_q;
    logic [15:0] glitch_cnt_q;

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            deviating_q  <= 1'b0;
            glitch_cnt_q <= '0;
        end else if (rise || fall) begin
            deviating_q <= 1'b0;
        end else if (pins_s2.clk != state_q) begin
            deviating_q <= 1'b1;
        end else if (deviating_q) begin
            deviating_q <= 1'b0;
            if (glitch_cnt_q != 16'hFFFF) begin
                glitch_cnt_q <= glitch_cnt_q + 16'd1;
            end
        end
    end

    assign bus.glitch_count = glitch_cnt_q;
`else
    assign bus.glitch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ram_bus_sync.sv
// tb_ram_bus_sync
// Drives the PSRAM pins through ram_bus_sync_if and compares the sampler
// against a transaction-level model: every clean rising pin edge schedules
// one expected strobe FILTER_DEPTH+3 cycles later carrying the decoded pins,
// every clean fall sets the expected nfilter_d, and every sub-FILTER_DEPTH
// pulse counts as one rejected glitch.
module tb_ram_bus_sync;

    localparam int FILTER_DEPTH = 3;
    localparam int LAT          = FILTER_DEPTH + 3;
    localparam int MIN_HALF     = FILTER_DEPTH + 3;

    logic mclk  = 1'b0;
    logic reset = 1'b1;

    ram_bus_sync_if bus();

    ram_bus_sync #(.FILTER_DEPTH(FILTER_DEPTH)) dut (
        .mclk  (mclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 mclk = ~mclk;

    typedef struct packed {
        logic [22:0] a;
        logic [15:0] d;
        logic [1:0]  ublb;
        logic        rd;
        logic        wr;
        logic        al;
    } view_t;

    typedef struct {
        int    due;
        view_t v;
    } event_t;

    event_t      exp_q[$];
    view_t       exp_view;
    logic [15:0] exp_nf;
    int          glitch_exp;
    int          cyc;
    int          strobes;
    int          checks;
    int          errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic view_t observed();
        return {bus.filter_a, bus.filter_d, bus.filter_ublb,
                bus.filter_read, bus.filter_write, bus.filter_addr_latch};
    endfunction

    // Transaction view implied by the pins currently driven.
    function automatic view_t expected_from_pins();
        view_t v;
        logic  selected;
        selected = (bus.ram_ce1 == 1'b0) && (bus.ram_ce2 == 1'b1);
        v.a    = bus.ram_a;
        v.d    = bus.ram_d;
        v.ublb = {bus.ram_ub == 1'b0, bus.ram_lb == 1'b0};
        v.wr   = selected && (bus.ram_we == 1'b0);
        v.rd   = selected && (bus.ram_oe == 1'b0) && (bus.ram_we == 1'b1);
        v.al   = selected && (bus.ram_adv == 1'b0);
        return v;
    endfunction

    // One mclk cycle: compare on the falling edge, then let the caller drive.
    task automatic tick();
        logic exp_stb;
        @(negedge mclk);
        cyc++;
        exp_stb = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        if (bus.filter_strobe) strobes++;
        check("filter_strobe", bus.filter_strobe, exp_stb);
        if (exp_stb) begin
            exp_view = exp_q[0].v;
            void'(exp_q.pop_front());
        end
        check("filter_snapshot", observed(), exp_view);
    endtask

    task automatic check_glitch();
`ifdef RAM_BUS_SYNC_GLITCH_CNT_EN
        check("glitch_count", bus.glitch_count, glitch_exp);
`else
        check("glitch_count", bus.glitch_count, 0);
`endif
    endtask

    task automatic set_bus(input logic [22:0] a, input logic [15:0] d,
                           input logic oe, input logic we, input logic ce1,
                           input logic ce2, input logic ub, input logic lb,
                           input logic adv);
        bus.ram_a   = a;
        bus.ram_d   = d;
        bus.ram_oe  = oe;
        bus.ram_we  = we;
        bus.ram_ce1 = ce1;
        bus.ram_ce2 = ce2;
        bus.ram_ub  = ub;
        bus.ram_lb  = lb;
        bus.ram_adv = adv;
    endtask

    task automatic rise_edge();
        bus.ram_clk = 1'b1;
        exp_q.push_back('{due: cyc + LAT, v: expected_from_pins()});
    endtask

    // Short pulse away from the current settled level, then settle again.
    task automatic glitch(input logic level_now, input int len);
        bus.ram_clk = ~level_now;
        repeat (len) tick();
        bus.ram_clk = level_now;
        repeat (MIN_HALF) tick();
        glitch_exp++;
        check_glitch();
    endtask

    // Clean ram_clk period; optional short low glitch inside the high phase.
    task automatic clock_pulse(input int hi, input int lo, input logic [15:0] d_fall,
                               input int hi_glitch);
        rise_edge();
        repeat (hi) tick();
        if (hi_glitch > 0) glitch(1'b1, hi_glitch);
        bus.ram_clk = 1'b0;
        bus.ram_d   = d_fall;
        exp_nf      = d_fall;
        repeat (lo) tick();
        check("nfilter_d", bus.nfilter_d, exp_nf);
    endtask

    initial begin
        int          s0;
        logic [31:0] r;
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        strobes    = 0;
        glitch_exp = 0;
        exp_view   = '0;
        exp_nf     = '0;
        bus.ram_clk = 1'b0;
        set_bus(23'h0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

        // Reset and idle: nothing may strobe, every output stays zero.
        repeat (3) tick();
        reset = 1'b0;
        repeat (100) tick();
        check("idle_strobes", strobes, 0);
        check("idle_nfilter_d", bus.nfilter_d, 16'h0);
        check_glitch();

        // Address latch cycle.
        set_bus(23'h12345, 16'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        s0 = strobes;
        clock_pulse(8, 8, 16'h0, 0);
        check("al_strobe_count", strobes - s0, 1);
        check("al_flag", bus.filter_addr_latch, 1'b1);
        check("al_addr", bus.filter_a, 23'h12345);
        check("al_rw", {bus.filter_read, bus.filter_write}, 2'b00);

        // Write burst, upper byte only.
        set_bus(23'h12345, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        s0 = strobes;
        repeat (4) clock_pulse(MIN_HALF + 1, MIN_HALF + 1, 16'hBEEF, 0);
        check("wr_strobe_count", strobes - s0, 4);
        check("wr_flag", bus.filter_write, 1'b1);
        check("wr_ublb", bus.filter_ublb, 2'b10);
        check("wr_data", bus.filter_d, 16'hBEEF);

        // Read with different data at the falling edge.
        set_bus(23'h00ABC, 16'hA5A5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        s0 = strobes;
        clock_pulse(8, 8, 16'h5A5A, 0);
        check("rd_strobe_count", strobes - s0, 1);
        check("rd_flag", bus.filter_read, 1'b1);
        check("rd_data", bus.filter_d, 16'hA5A5);
        check("rd_nfilter_d", bus.nfilter_d, 16'h5A5A);

        // Sub-threshold pulses: the longest rejected width and the shortest.
        s0 = strobes;
        glitch(1'b0, FILTER_DEPTH - 1);
        glitch(1'b0, 1);
        check("glitch_strobe_count", strobes - s0, 0);

        // Reset one cycle after a rising pin edge.
        set_bus(23'h7FFFFF, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        rise_edge();
        tick();
        reset = 1'b1;
        #1;
        exp_q.delete();
        exp_view   = '0;
        exp_nf     = '0;
        glitch_exp = 0;
        check("rst_snapshot", observed(), 44'h0);
        check("rst_strobe", bus.filter_strobe, 1'b0);
        check("rst_nfilter_d", bus.nfilter_d, 16'h0);
        check_glitch();
        bus.ram_clk = 1'b0;
        s0 = strobes;
        repeat (4) tick();
        reset = 1'b0;
        repeat (MIN_HALF + 2) tick();
        check("rst_no_strobe", strobes - s0, 0);
        clock_pulse(MIN_HALF, MIN_HALF, 16'h4321, 0);
        check("post_rst_strobe_count", strobes - s0, 1);

        // Randomised transactions with occasional glitches in either phase.
        for (int i = 0; i < 60; i++) begin
            logic [22:0] a;
            logic [15:0] d;
            logic [15:0] d_fall;
            logic [6:0]  ctl;
            int          hi;
            int          lo;
            int          hg;
            r      = $urandom;
            a      = r[22:0];
            r      = $urandom;
            d      = r[15:0];
            d_fall = r[31:16];
            r      = $urandom;
            ctl    = r[6:0];
            // Bias chip-select toward selected so decode paths get exercised.
            if (r[8:7] != 2'b00) begin
                ctl[2] = 1'b0;
                ctl[3] = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) glitch(1'b0, $urandom_range(1, FILTER_DEPTH - 1));
            set_bus(a, d, ctl[0], ctl[1], ctl[2], ctl[3], ctl[4], ctl[5], ctl[6]);
            hi = $urandom_range(MIN_HALF, MIN_HALF + 5);
            lo = $urandom_range(MIN_HALF, MIN_HALF + 5);
            hg = ($urandom_range(0, 3) == 0) ? $urandom_range(1, FILTER_DEPTH - 1) : 0;
            clock_pulse(hi, lo, d_fall, hg);
        end

        repeat (LAT + 2) tick();
        check("pending_strobes", exp_q.size(), 0);
        check_glitch();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
